instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_pkg.sv | 43 ++++
 rtl/instr_fetch.sv | 104 ++++++++++
 2 files changed

// File: rtl/instr_pkg.sv
// Shared opcodes, operand constants, FSM states and the power-on program
// loaded into the instruction store on reset.
package instr_pkg;

  typedef enum logic [2:0] {
    CLRLD = 3'd0,
    ADDLD = 3'd1,
    ADD   = 3'd2,
    DIV2  = 3'd3,
    DISP  = 3'd4
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    HALT    = 2'd3
  } state_e;

  localparam int A = 4;
  localparam int B = 2;

  // Every address beyond the five-entry program holds DISP, so a run can
  // never walk into undefined code.
  function automatic int default_op(input int addr);
    case (addr)
      0:       return int'(CLRLD);
      1:       return int'(ADDLD);
      2:       return int'(ADD);
      3:       return int'(DIV2);
      default: return int'(DISP);
    endcase
  endfunction

  function automatic int default_val(input int addr);
    case (addr)
      0:       return A;
      1:       return B;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: a small writable program store walked by a
// FETCH/PRESENT handshake FSM, halting (or looping) on DISP or the last address.
module instr_fetch
  import instr_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 3,
  parameter int VAL_W  = 4,
  parameter int LOOP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [OP_W-1:0]   wr_funcao,
  input  logic [VAL_W-1:0]  wr_valor,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [OP_W-1:0]   funcao,
  output logic [VAL_W-1:0]  valor,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [OP_W-1:0]   OP_DISP   = OP_W'(DISP);

  state_e           state;
  logic [OP_W-1:0]  rd_op  [DEPTH];
  logic [VAL_W-1:0] rd_val [DEPTH];
  logic             wr_ok;
  logic             prog_end;

  assign wr_ok    = wr_en && (state == IDLE);
  assign prog_end = (funcao == OP_DISP) || (pc == LAST_ADDR);
  assign busy     = (state != IDLE);

  // One register pair per word so each can reload its own default on reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [OP_W-1:0]  op_q;
    logic [VAL_W-1:0] val_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_q  <= OP_W'(default_op(g));
        val_q <= VAL_W'(default_val(g));
      end else if (wr_ok && (wr_addr == ADDR_W'(g))) begin
        op_q  <= wr_funcao;
        val_q <= wr_valor;
      end
    end

    assign rd_op[g]  = op_q;
    assign rd_val[g] = val_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      funcao      <= '0;
      valor       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          funcao      <= rd_op[pc];
          valor       <= rd_val[pc];
          instr_valid <= 1'b1;
          state       <= PRESENT;
        end
        PRESENT: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            if (!prog_end) begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end else if (LOOP != 0) begin
              pc    <= '0;
              state <= FETCH;
            end else begin
              state <= HALT;
              done  <= 1'b1;
            end
          end
        end
        HALT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
